// File: rtl/ras_stack_pkg.sv
// Shared types and helpers for the return-address stack (ras_stack).
package ras_stack_pkg;

    localparam int unsigned RAS_DEPTH_DEFAULT = 32'd2;
    localparam int unsigned RAS_VLEN_DEFAULT  = 32'd64;

    typedef enum logic [2:0] {
        RAS_OP_IDLE      = 3'd0,
        RAS_OP_FLUSH     = 3'd1,
        RAS_OP_RESTORE   = 3'd2,
        RAS_OP_PUSH      = 3'd3,
        RAS_OP_POP       = 3'd4,
        RAS_OP_REPLACE   = 3'd5,
        RAS_OP_UNDERFLOW = 3'd6
    } ras_op_e;

    // Resolves the per-cycle request set into one operation, highest priority first.
    function automatic ras_op_e ras_op_decode(
        input logic flush,
        input logic restore,
        input logic push,
        input logic pop,
        input logic empty
    );
        ras_op_e op;
        if (flush) begin
            op = RAS_OP_FLUSH;
        end else if (restore) begin
            op = RAS_OP_RESTORE;
        end else if (push && pop && !empty) begin
            op = RAS_OP_REPLACE;
        end else if (push) begin
            op = RAS_OP_PUSH;
        end else if (pop && !empty) begin
            op = RAS_OP_POP;
        end else if (pop) begin
            op = RAS_OP_UNDERFLOW;
        end else begin
            op = RAS_OP_IDLE;
        end
        return op;
    endfunction

endpackage

// File: rtl/ras_ckpt_reg.sv
// Snapshot register for ras_stack speculative repair.
// Only built when CVA6_RAS_CKPT_EN is defined.
`ifdef CVA6_RAS_CKPT_EN
module ras_ckpt_reg
    import ras_stack_pkg::*;
#(
    parameter int unsigned PTR_W = 32'd1,
    parameter int unsigned CNT_W = 32'd2,
    parameter int unsigned VLEN  = RAS_VLEN_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ckpt_i,
    input  logic             restore_i,
    input  logic [PTR_W-1:0] tos_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [VLEN-1:0]  ra_i,
    output logic [PTR_W-1:0] saved_tos_o,
    output logic [CNT_W-1:0] saved_count_o,
    output logic [VLEN-1:0]  saved_ra_o
);

    logic             capture_s;
    logic [PTR_W-1:0] tos_r;
    logic [CNT_W-1:0] count_r;
    logic [VLEN-1:0]  ra_r;

    // A restore in the same cycle wins over a new checkpoint.
    assign capture_s = ckpt_i & ~restore_i;

    // Snapshot storage, captured from the pre-update stack state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tos_r   <= '0;
            count_r <= '0;
            ra_r    <= '0;
        end else if (capture_s) begin
            tos_r   <= tos_i;
            count_r <= count_i;
            ra_r    <= ra_i;
        end
    end

    assign saved_tos_o   = tos_r;
    assign saved_count_o = count_r;
    assign saved_ra_o    = ra_r;

endmodule
`endif

// File: rtl/ras_stack.sv
// Circular return-address stack; oldest entry is overwritten on overflow.
// Optional checkpoint/restore repair path enabled by CVA6_RAS_CKPT_EN.
module ras_stack
    import ras_stack_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT,
    parameter int unsigned VLEN  = RAS_VLEN_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [VLEN-1:0] data_i,
    input  logic          ckpt_i,
    input  logic          restore_i,
    output logic [VLEN:0] ras_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 32'd1);

    logic [VLEN-1:0]  mem_r [DEPTH];
    logic [PTR_W-1:0] tos_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic             underflow_r;

    logic [PTR_W-1:0] tos_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [PTR_W-1:0] tos_inc_s;
    logic             wr_en_s;
    logic [PTR_W-1:0] wr_idx_s;
    logic [VLEN-1:0]  wr_data_s;
    logic             overflow_s;
    logic             underflow_s;
    logic             empty_s;
    logic             full_s;
    logic             restore_s;
    ras_op_e          op_s;

    logic [PTR_W-1:0] saved_tos_s;
    logic [CNT_W-1:0] saved_count_s;
    logic [VLEN-1:0]  saved_ra_s;

`ifdef CVA6_RAS_CKPT_EN
    assign restore_s = restore_i;

    ras_ckpt_reg #(
        .PTR_W (PTR_W),
        .CNT_W (CNT_W),
        .VLEN  (VLEN)
    ) u_ckpt (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ckpt_i        (ckpt_i),
        .restore_i     (restore_i),
        .tos_i         (tos_r),
        .count_i       (count_r),
        .ra_i          (mem_r[tos_r]),
        .saved_tos_o   (saved_tos_s),
        .saved_count_o (saved_count_s),
        .saved_ra_o    (saved_ra_s)
    );
`else
    logic unused_ckpt_s;
    assign unused_ckpt_s = ckpt_i ^ restore_i;
    assign restore_s     = 1'b0;
    assign saved_tos_s   = '0;
    assign saved_count_s = '0;
    assign saved_ra_s    = '0;
`endif

    assign empty_s   = (count_r == '0);
    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign tos_inc_s = tos_r + PTR_W'(1);
    assign op_s      = ras_op_decode(flush_i, restore_s, push_i, pop_i, empty_s);

    // Next-state and write-port selection for the decoded operation.
    always_comb begin
        tos_nxt_s   = tos_r;
        count_nxt_s = count_r;
        wr_en_s     = 1'b0;
        wr_idx_s    = tos_r;
        wr_data_s   = data_i;
        overflow_s  = 1'b0;
        underflow_s = 1'b0;
        case (op_s)
            RAS_OP_FLUSH: begin
                tos_nxt_s   = '0;
                count_nxt_s = '0;
            end
            RAS_OP_RESTORE: begin
                tos_nxt_s   = saved_tos_s;
                count_nxt_s = saved_count_s;
                wr_en_s     = 1'b1;
                wr_idx_s    = saved_tos_s;
                wr_data_s   = saved_ra_s;
            end
            RAS_OP_REPLACE: begin
                wr_en_s = 1'b1;
            end
            RAS_OP_PUSH: begin
                tos_nxt_s = tos_inc_s;
                wr_en_s   = 1'b1;
                wr_idx_s  = tos_inc_s;
                if (full_s) begin
                    overflow_s = 1'b1;
                end else begin
                    count_nxt_s = count_r + CNT_W'(1);
                end
            end
            RAS_OP_POP: begin
                tos_nxt_s   = tos_r - PTR_W'(1);
                count_nxt_s = count_r - CNT_W'(1);
            end
            RAS_OP_UNDERFLOW: begin
                underflow_s = 1'b1;
            end
            RAS_OP_IDLE: begin
                wr_en_s = 1'b0;
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Stack pointer, occupancy and status pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tos_r       <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            tos_r       <= tos_nxt_s;
            count_r     <= count_nxt_s;
            overflow_r  <= overflow_s;
            underflow_r <= underflow_s;
        end
    end

    // Entry storage; flush leaves contents in place.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_r[wr_idx_s] <= wr_data_s;
        end
    end

    assign ras_o       = {~empty_s, mem_r[tos_r]};
    assign overflow_o  = overflow_r;
    assign underflow_o = underflow_r;

endmodule

// File: tb/tb_ras_stack.sv
// Scoreboard bench for ras_stack (DEPTH=2, VLEN=64); expectations follow CVA6_RAS_CKPT_EN.
module tb_ras_stack;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned VLEN  = 64;
`ifdef CVA6_RAS_CKPT_EN
    localparam bit CKPT = 1'b1;
`else
    localparam bit CKPT = 1'b0;
`endif

    logic            clk;
    logic            rst_i;
    logic            flush_i;
    logic            push_i;
    logic            pop_i;
    logic [VLEN-1:0] data_i;
    logic            ckpt_i;
    logic            restore_i;
    logic [VLEN:0]   ras_o;
    logic            overflow_o;
    logic            underflow_o;

    typedef struct {
        string           name;
        logic [VLEN:0]   ras;
        logic            ovf;
        logic            udf;
        int              due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    ras_stack #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (push_i),
        .pop_i       (pop_i),
        .data_i      (data_i),
        .ckpt_i      (ckpt_i),
        .restore_i   (restore_i),
        .ras_o       (ras_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: pop every expectation that is due and compare against the outputs.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if (ras_o !== mon_e.ras) begin
                n_bad++;
                $display("FAIL %s ras: got %h want %h", mon_e.name, ras_o, mon_e.ras);
            end
            n_cmp++;
            if (overflow_o !== mon_e.ovf) begin
                n_bad++;
                $display("FAIL %s overflow: got %b want %b", mon_e.name, overflow_o, mon_e.ovf);
            end
            n_cmp++;
            if (underflow_o !== mon_e.udf) begin
                n_bad++;
                $display("FAIL %s underflow: got %b want %b", mon_e.name, underflow_o, mon_e.udf);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic f, input logic pu,
                        input logic po, input logic ck, input logic rs, input logic [VLEN-1:0] d,
                        input logic ev, input logic [VLEN-1:0] era, input logic eo, input logic eu);
        exp_t e;
        @(posedge clk);
        #1;
        rst_i     = r;
        flush_i   = f;
        push_i    = pu;
        pop_i     = po;
        ckpt_i    = ck;
        restore_i = rs;
        data_i    = d;
        e.name = nm;
        e.ras  = {ev, era};
        e.ovf  = eo;
        e.udf  = eu;
        e.due  = cyc + 1;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
        ckpt_i = 1'b0; restore_i = 1'b0; data_i = '0;

        //    name          rst f  pu po ck rs data       v  ra         ov ud
        step("reset",       1, 0, 0, 0, 0, 0, 64'h0,     0, 64'h0,     0, 0);
        step("idle",        0, 0, 0, 0, 0, 0, 64'h0,     0, 64'h0,     0, 0);
        step("push1",       0, 0, 1, 0, 0, 0, 64'h1000,  1, 64'h1000,  0, 0);
        // full / overflow / drain / underflow
        step("flush",       0, 1, 0, 0, 0, 0, 64'h0,     0, 64'h0,     0, 0);
        step("s2_push1",    0, 0, 1, 0, 0, 0, 64'h1000,  1, 64'h1000,  0, 0);
        step("s2_push2",    0, 0, 1, 0, 0, 0, 64'h2000,  1, 64'h2000,  0, 0);
        step("s2_push3",    0, 0, 1, 0, 0, 0, 64'h3000,  1, 64'h3000,  1, 0);
        step("s2_pop1",     0, 0, 0, 1, 0, 0, 64'h0,     1, 64'h2000,  0, 0);
        step("s2_pop2",     0, 0, 0, 1, 0, 0, 64'h0,     0, 64'h3000,  0, 0);
        step("s2_pop3",     0, 0, 0, 1, 0, 0, 64'h0,     0, 64'h3000,  0, 1);
        step("s2_idle",     0, 0, 0, 0, 0, 0, 64'h0,     0, 64'h3000,  0, 0);
        // simultaneous push+pop
        step("s3_push",     0, 0, 1, 0, 0, 0, 64'h1000,  1, 64'h1000,  0, 0);
        step("s3_pushpop",  0, 0, 1, 1, 0, 0, 64'h4000,  1, 64'h4000,  0, 0);
        step("s3_pop",      0, 0, 0, 1, 0, 0, 64'h0,     0, 64'h3000,  0, 0);
        step("s3_popempty", 0, 0, 0, 1, 0, 0, 64'h0,     0, 64'h3000,  0, 1);
        step("s3_pp_empty", 0, 0, 1, 1, 0, 0, 64'h6000,  1, 64'h6000,  0, 0);
        // flush beats push, including a would-be overflow
        step("s4_flushpush",0, 1, 1, 0, 0, 0, 64'h5000,  0, 64'h6000,  0, 0);
        step("s4_pop",      0, 0, 0, 1, 0, 0, 64'h0,     0, 64'h6000,  0, 1);
        step("s4_push1",    0, 0, 1, 0, 0, 0, 64'h7000,  1, 64'h7000,  0, 0);
        step("s4_push2",    0, 0, 1, 0, 0, 0, 64'h8000,  1, 64'h8000,  0, 0);
        step("s4_flushovf", 0, 1, 1, 0, 0, 0, 64'hA000,  0, 64'h8000,  0, 0);
        // checkpoint / restore
        step("s5_push1",    0, 0, 1, 0, 0, 0, 64'h1000,  1, 64'h1000,  0, 0);
        step("s5_ckpt",     0, 0, 0, 0, 1, 0, 64'h0,     1, 64'h1000,  0, 0);
        step("s5_push2",    0, 0, 1, 0, 0, 0, 64'h2000,  1, 64'h2000,  0, 0);
        step("s5_pop1",     0, 0, 0, 1, 0, 0, 64'h0,     1, 64'h1000,  0, 0);
        step("s5_pop2",     0, 0, 0, 1, 0, 0, 64'h0,     0, 64'h2000,  0, 0);
        step("s5_restore",  0, 0, 0, 0, 0, 1, 64'h0,
             CKPT, CKPT ? 64'h1000 : 64'h2000, 0, 0);
        step("s5_rst_push", 0, 0, 1, 0, 0, 1, 64'h9000,
             1'b1, CKPT ? 64'h1000 : 64'h9000, 0, 0);
        // restore right after reset yields the empty reset snapshot
        step("s5_reset",    1, 0, 0, 0, 0, 0, 64'h0,     0, 64'h0,     0, 0);
        step("s5_rst_early",0, 0, 0, 0, 0, 1, 64'h0,     0, 64'h0,     0, 0);
        step("s5_idle",     0, 0, 0, 0, 0, 0, 64'h0,     0, 64'h0,     0, 0);

        @(posedge clk);
        #1;
        rst_i = 1'b0; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
        ckpt_i = 1'b0; restore_i = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ras_stack.md
# ras_stack

Return-address stack feeding the frontend branch-prediction stage. It pushes return addresses on calls and pops them on returns, exposing the current top entry to the next-PC select every cycle. It is sized from the core configuration (`RASDepth`, `VLEN`) and implemented as a circular buffer that overwrites the oldest entry on overflow. An optional checkpoint/restore path repairs the stack after a mispredicted speculative push or pop.

## Interface
- `DEPTH`, 2, number of entries (from `cva6_cfg.RASDepth`); must be ≥2 and a power of two
- `VLEN`, 64, return-address width (from `cva6_cfg.VLEN`)
- `clk_i` input 1: clock
- `rst_i` input 1: **synchronous, active-high reset; single clock domain (`clk_i`)**
- `flush_i` input 1: clear the stack (pipeline flush)
- `push_i` input 1: push `data_i`
- `pop_i` input 1: pop the top entry
- `data_i` input VLEN: return address to push
- `ckpt_i` input 1: take a snapshot (checkpoint feature only)
- `restore_i` input 1: restore the snapshot (checkpoint feature only)
- `ras_o` output `ras_t` (1+VLEN): `{valid, ra}` of the top entry
- `overflow_o` output 1: one-cycle pulse when a push overwrites the oldest entry
- `underflow_o` output 1: one-cycle pulse when a pop finds the stack empty

## Operation
**State**
- `mem[DEPTH]`: storage entries
- `tos`: top-of-stack pointer, log2(DEPTH) bits, wraps modulo DEPTH
- `count`: occupancy, 0..DEPTH

**Output**
- `ras_o.valid = (count != 0)`
- `ras_o.ra = mem[tos]`

**Priority per cycle:** `rst_i` > `flush_i` > `restore_i` > push/pop.
- Flush: `count := 0`, `tos := 0`. `mem` contents are kept.
- Push only:
  - `tos := tos+1` (wrap)
  - `mem[tos+1] := data_i`
  - `count := min(count+1, DEPTH)`
  - If `count == DEPTH` beforehand, pulse `overflow_o`.
- Pop only:
  - If `count > 0`: `tos := tos-1` (wrap), `count := count-1`.
  - If `count == 0`: no state change; pulse `underflow_o`.
- Push and pop together:
  - If `count > 0`: `mem[tos] := data_i`; `tos` and `count` are unchanged.
  - If `count == 0`: behave as a push only. No underflow pulse.
- Checkpoint: when `ckpt_i` is high, the snapshot register captures `{tos, count, mem[tos]}` using values from before this cycle's update. `ckpt_i` does not alter stack state.
- Restore: when `restore_i` is high, `tos`, `count` and `mem[saved_tos]` are loaded from the snapshot. Push, pop and `ckpt_i` in the same cycle are ignored. `restore_i` before any checkpoint restores the reset snapshot, which is empty.

## Timing
- Updates are registered. `ras_o` reflects an operation in the cycle after it. The read of the top entry is combinational from registers, so it has zero added latency.
- There is no handshake; every request is accepted every cycle.
- Reset values:
  - `count` = 0, `tos` = 0, `mem` all 0, snapshot all 0
  - `ras_o` = `'0`
  - `overflow_o` = 0, `underflow_o` = 0
- `overflow_o` and `underflow_o` are registered pulses, asserted the cycle after the causing request. Both are 0 in any cycle following a flush, restore or reset.
- Reset during operation discards any in-flight request in that cycle.

## Configuration
- Macro: `CVA6_RAS_CKPT_EN`.
- Defined: the snapshot register and the restore path are instantiated as described above.
- Undefined:
  - No snapshot storage is built.
  - `ckpt_i` and `restore_i` are present but ignored.
  - Priority becomes reset > flush > push/pop.

## Structure
- `ras_t` (`logic valid; logic [VLEN-1:0] ra`) belongs in `ariane_pkg`, parameterized through `cva6_cfg`. The frontend consumes it.
- One sub-module, `ras_ckpt_reg`, holds the snapshot and its capture/restore muxing. It is instantiated only under `CVA6_RAS_CKPT_EN`.

## Test plan
All scenarios use DEPTH=2, VLEN=64.
1. Reset, then idle → `ras_o` = `{0, 0}`, no pulses. Push `0x1000` → next cycle `ras_o` = `{1, 0x1000}`.
2. Push `0x1000`, `0x2000`, `0x3000` → `overflow_o` pulses after the third push. Pop → `ras_o.ra` = `0x2000`. Pop → `valid` = 0. Pop → `underflow_o` = 1.
3. With `count` = 1 and top `0x1000`, assert push `0x4000` and pop together → `ras_o` = `{1, 0x4000}`, `count` still 1.
4. Assert flush and push `0x5000` together → next cycle `ras_o.valid` = 0; stack empty.
5. Macro on: push `0x1000`, checkpoint, push `0x2000`, pop, pop (empty), then restore → `ras_o` = `{1, 0x1000}`. Restore in the same cycle as a push `0x9000` → the push is ignored.
6. Macro off: repeat scenario 5 → restore has no effect; `ras_o.valid` = 0 after the pops.
